// File: rtl/eq_pkg.sv
//------------------------------------------------------------------
// eq_pkg : types and constants shared across the equalizer datapath
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package eq_pkg;

  localparam int NUM_BANDS_MAX = 8;

  typedef logic [2:0] band_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/eq_fir_sched_if.sv
//------------------------------------------------------------------
// eq_fir_sched_if : scheduler <-> queue writer / MAC core / summer
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface eq_fir_sched_if
  import eq_pkg::*;
#(
  parameter int AW = 10
) ();

  logic          smpl_vld;
  logic [AW-1:0] wr_ptr;
  logic [15:0]   fir_result;
  logic          sequencing;
  band_t         band_sel;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          band_vld;
  logic [15:0]   band_smpl;
  band_t         band_idx;
  logic          frame_done;
  logic          overrun;

  // Surrounding datapath: drives samples and core output, consumes results
  modport master (
    output smpl_vld, wr_ptr, fir_result,
    input  sequencing, band_sel, rd_addr, busy, band_vld, band_smpl,
           band_idx, frame_done, overrun
  );

  modport slave (
    input  smpl_vld, wr_ptr, fir_result,
    output sequencing, band_sel, rd_addr, busy, band_vld, band_smpl,
           band_idx, frame_done, overrun
  );

endinterface

`default_nettype wire

// File: rtl/eq_rd_addr_gen.sv
//------------------------------------------------------------------
// eq_rd_addr_gen : circular sample-queue read address, newest first
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module eq_rd_addr_gen #(
  parameter int AW        = 10,
  parameter int NUM_COEFF = 1021
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          start,
  input  wire logic          restart,
  input  wire logic          advance,
  input  wire logic [AW-1:0] wr_ptr,
  output logic      [AW-1:0] rd_addr,
  output logic               last_tap
);

  localparam int TW = $clog2(NUM_COEFF) + 1;

  logic [AW-1:0] base;
  logic [TW-1:0] tap;
  logic [TW-1:0] tap_inc;

  assign tap_inc  = tap + TW'(1);
  assign last_tap = (tap == TW'(NUM_COEFF - 1));

  // Address is registered alongside the tap so it tracks base - tap exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      tap     <= '0;
      rd_addr <= '0;
    end else if (start) begin
      base    <= wr_ptr;
      tap     <= '0;
      rd_addr <= wr_ptr;
    end else if (restart) begin
      tap     <= '0;
      rd_addr <= base;
    end else if (advance) begin
      tap     <= tap_inc;
      rd_addr <= base - AW'(tap_inc);
    end
  end

endmodule

`default_nettype wire

// File: rtl/eq_fir_sched.sv
//------------------------------------------------------------------
// eq_fir_sched : runs the shared FIR MAC core once per band per sample
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module eq_fir_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5,
  parameter int NUM_COEFF = 1021,
  parameter int DRAIN     = 2,
  parameter int AW        = 10
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  eq_fir_sched_if.slave bus
);

  localparam int DW = $clog2(DRAIN + 1) + 1;

  sched_state_t state, state_next;
  band_t        band, band_next;
  logic [DW-1:0] dcnt, dcnt_next;

  logic        start, restart, advance, last_tap;
  logic        sequencing_r, busy_r, band_vld_r, frame_done_r, overrun_r;
  logic [15:0] band_smpl_r;
  band_t       band_idx_r;

  eq_rd_addr_gen #(
    .AW        (AW),
    .NUM_COEFF (NUM_COEFF)
  ) u_rd_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .restart  (restart),
    .advance  (advance),
    .wr_ptr   (bus.wr_ptr),
    .rd_addr  (bus.rd_addr),
    .last_tap (last_tap)
  );

  always_comb begin
    state_next = state;
    band_next  = band;
    dcnt_next  = dcnt;
    start      = 1'b0;
    restart    = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.smpl_vld) begin
          state_next = ST_RUN;
          band_next  = '0;
          start      = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_tap) begin
          state_next = (DRAIN == 0) ? ST_CAPT : ST_DRAIN;
          dcnt_next  = '0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (dcnt == DW'(DRAIN - 1)) begin
          state_next = ST_CAPT;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      ST_CAPT: begin
        // The single low-sequencing cycle here clears the core accumulator
        if (band == band_t'(NUM_BANDS - 1)) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
          band_next  = band + band_t'(1);
          restart    = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        band_next  = '0;
      end
      default: begin
        state_next = ST_IDLE;
        band_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      band  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      band  <= band_next;
      dcnt  <= dcnt_next;
    end
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sequencing_r <= 1'b0;
      busy_r       <= 1'b0;
      band_vld_r   <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
      band_smpl_r  <= '0;
      band_idx_r   <= '0;
    end else begin
      sequencing_r <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
      busy_r       <= (state_next != ST_IDLE);
      frame_done_r <= (state_next == ST_DONE);
      band_vld_r   <= (state == ST_CAPT);
      if (state == ST_CAPT) begin
        band_smpl_r <= bus.fir_result;
        band_idx_r  <= band;
      end
      if (bus.smpl_vld && (state != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign bus.sequencing = sequencing_r;
  assign bus.band_sel   = band;
  assign bus.busy       = busy_r;
  assign bus.band_vld   = band_vld_r;
  assign bus.band_smpl  = band_smpl_r;
  assign bus.band_idx   = band_idx_r;
  assign bus.frame_done = frame_done_r;
  assign bus.overrun    = overrun_r;

endmodule

`default_nettype wire

// File: tb/tb_eq_fir_sched.sv
//------------------------------------------------------------------
// tb_eq_fir_sched : randomized frames against a cycle-formula model
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_eq_fir_sched;

  localparam int NB = 3;
  localparam int NC = 8;
  localparam int DR = 2;
  localparam int AW = 4;
  localparam int P  = NC + DR + 1;
  localparam int FL = NB * P + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_fir_sched_if #(.AW(AW)) bus ();

  eq_fir_sched #(
    .NUM_BANDS (NB),
    .NUM_COEFF (NC),
    .DRAIN     (DR),
    .AW        (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]   m_smpl = '0;
  logic [2:0]    m_idx  = '0;
  logic          m_ovr  = 1'b0;
  logic [AW-1:0] m_rd   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_seq"},   32'(bus.sequencing), 32'(0));
    check({tag, "_busy"},  32'(bus.busy),       32'(0));
    check({tag, "_bsel"},  32'(bus.band_sel),   32'(0));
    check({tag, "_vld"},   32'(bus.band_vld),   32'(0));
    check({tag, "_done"},  32'(bus.frame_done), 32'(0));
    check({tag, "_rd"},    32'(bus.rd_addr),    32'(m_rd));
    check({tag, "_smpl"},  32'(bus.band_smpl),  32'(m_smpl));
    check({tag, "_idx"},   32'(bus.band_idx),   32'(m_idx));
    check({tag, "_ovr"},   32'(bus.overrun),    32'(m_ovr));
  endtask

  // Frame model: band k occupies cycles k*P+1 .. (k+1)*P; within a band,
  // offsets 0..NC-1 are taps, then DR drain cycles, then one capture cycle.
  task automatic run_frame(input logic [AW-1:0] base, input int ovr_c,
                           input bit pat, input int abort_c);
    logic [15:0] cur_fir;
    logic [15:0] prev_fir;
    int k;
    int o;
    bit exp_vld;
    int exp_bsel;
    bus.smpl_vld   = 1'b1;
    bus.wr_ptr     = base;
    cur_fir        = 16'($urandom);
    bus.fir_result = cur_fir;
    prev_fir       = cur_fir;
    for (int c = 1; c <= FL + 2; c++) begin
      tick();
      bus.smpl_vld = 1'b0;
      k = (c - 1) / P;
      o = (c - 1) % P;
      if (c <= NB * P) m_rd = base - AW'((o < NC) ? o : NC - 1);
      else             m_rd = base - AW'(NC - 1);
      exp_vld = (c > 1) && (o == 0) && (k >= 1) && (c <= FL);
      if (exp_vld) begin
        m_smpl = prev_fir;
        m_idx  = 3'(k - 1);
      end
      if (c <= NB * P)   exp_bsel = k;
      else if (c == FL)  exp_bsel = NB - 1;
      else               exp_bsel = 0;
      check("seq",   32'(bus.sequencing), 32'((c <= NB * P) && (o < NC + DR)));
      check("busy",  32'(bus.busy),       32'(c <= FL));
      check("bsel",  32'(bus.band_sel),   32'(exp_bsel));
      check("rd",    32'(bus.rd_addr),    32'(m_rd));
      check("vld",   32'(bus.band_vld),   32'(exp_vld));
      check("smpl",  32'(bus.band_smpl),  32'(m_smpl));
      check("idx",   32'(bus.band_idx),   32'(m_idx));
      check("done",  32'(bus.frame_done), 32'(c == FL));
      check("ovr",   32'(bus.overrun),    32'(m_ovr));
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        #1;
        m_smpl = '0;
        m_idx  = '0;
        m_ovr  = 1'b0;
        m_rd   = '0;
        check_idle("async_rst");
        return;
      end
      if (pat && (c <= NB * P) && (o == NC + DR)) cur_fir = 16'(32'h1111 * (k + 1));
      else                                        cur_fir = 16'($urandom);
      bus.fir_result = cur_fir;
      prev_fir       = cur_fir;
      if (c == ovr_c) begin
        bus.smpl_vld = 1'b1;
        bus.wr_ptr   = AW'($urandom);
        if (c <= FL) m_ovr = 1'b1;
      end
    end
  endtask

  initial begin
    bus.smpl_vld   = 1'b0;
    bus.wr_ptr     = '0;
    bus.fir_result = '0;

    repeat (3) tick();
    check_idle("in_rst");
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      check_idle("idle");
    end

    run_frame(4'd9, 0, 1'b1, 0);
    run_frame(4'd2, 0, 1'b0, 0);
    repeat (3) run_frame(AW'($urandom), 0, 1'b0, 0);

    run_frame(AW'($urandom), 20, 1'b0, 0);
    run_frame(4'd5, 0, 1'b0, 0);

    run_frame(AW'($urandom), 0, 1'b0, 15);
    repeat (3) begin
      tick();
      check_idle("rst_hold");
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check_idle("post_rst");
    end
    run_frame(4'd3, 0, 1'b0, 0);

    run_frame(4'd7, FL, 1'b0, 0);
    tick();
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
